acc_mem_bridge: RTL

// - Memory-mapped bridge between the core's single-port RAM-style slave port and a parallel

---
 rtl/acc_mem_bridge_if.sv | 16 +
 rtl/acc_mem_bridge.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/acc_mem_bridge_if.sv
// Slave bus between the core's data-RAM port and acc_mem_bridge.
// The master drives request/address/data; the bridge returns registered read data.
interface acc_mem_bridge_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                    en_i;
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic                    we_i;
    logic [DATA_WIDTH/8-1:0] be_i;
    logic [DATA_WIDTH-1:0]   rdata_o;

    modport master (output en_i, addr_i, wdata_i, we_i, be_i, input rdata_o);
    modport slave  (input en_i, addr_i, wdata_i, we_i, be_i, output rdata_o);
endinterface

// File: rtl/acc_mem_bridge.sv
// acc_mem_bridge: memory-mapped front end for a parallel accelerator.
// Regions: A (RW operands), B (RW operands), R (RO results), CSR (CTRL/STATUS/CYCLES).
// Optional feature macro: ACC_BRIDGE_TIMEOUT_EN -- abort a BUSY run after
// TIMEOUT_CYCLES cycles without acc_done_i (STATUS bit3 flags it).
module acc_mem_bridge #(
    parameter int N_WORDS        = 256,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = $clog2(N_WORDS) + $clog2(DATA_WIDTH/8) + 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rstn_i,
    acc_mem_bridge_if.slave               bus,
    output logic [N_WORDS*DATA_WIDTH-1:0] acc_in_A_o,
    output logic [N_WORDS*DATA_WIDTH-1:0] acc_in_B_o,
    output logic                          acc_start_o,
    input  logic                          acc_done_i,
    input  logic [N_WORDS*DATA_WIDTH-1:0] acc_out_i,
    output logic                          busy_o
);
    localparam int NB        = DATA_WIDTH / 8;
    localparam int BYTE_BITS = $clog2(NB);
    localparam int WORD_BITS = $clog2(N_WORDS);

    localparam logic [1:0] REG_A = 2'b00;
    localparam logic [1:0] REG_B = 2'b01;
    localparam logic [1:0] REG_R = 2'b10;
    localparam logic [1:0] REG_C = 2'b11;

    typedef logic [N_WORDS-1:0][DATA_WIDTH-1:0] bank_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    bank_t                 r_bank_a, r_bank_b, r_bank_r;
    logic [DATA_WIDTH-1:0] r_rdata, r_cycles;
    logic                  r_done, r_err, r_timeout;

    logic [1:0]            w_region;
    logic [WORD_BITS-1:0]  w_word;
    logic                  w_wr, w_ctrl_wr, w_start_req, w_clear_req, w_start_go;
    logic                  w_ab_wr, w_busy, w_take_done, w_take_to, w_timeout_hit;
    logic [DATA_WIDTH-1:0] w_rdata, w_cycles_inc;

    assign w_region    = bus.addr_i[ADDR_WIDTH-1 -: 2];
    assign w_word      = bus.addr_i[ADDR_WIDTH-3 -: WORD_BITS];
    assign w_wr        = bus.en_i & bus.we_i;
    assign w_ctrl_wr   = w_wr && (w_region == REG_C) && (w_word == WORD_BITS'(0));
    // Clear outranks start when both bits are written together.
    assign w_clear_req = w_ctrl_wr & bus.wdata_i[1];
    assign w_start_req = w_ctrl_wr & bus.wdata_i[0] & ~bus.wdata_i[1];
    assign w_busy      = (r_state == S_START) || (r_state == S_BUSY);
    assign w_start_go  = w_start_req & ~w_busy;
    assign w_ab_wr     = w_wr && ((w_region == REG_A) || (w_region == REG_B));
    assign w_cycles_inc = (r_cycles == '1) ? r_cycles : r_cycles + 1'b1;

    assign acc_in_A_o  = r_bank_a;
    assign acc_in_B_o  = r_bank_b;
    assign acc_start_o = (r_state == S_START);
    assign busy_o      = w_busy;
    assign bus.rdata_o = r_rdata;

    generate
        if (BYTE_BITS > 0) begin : g_addr_lo
            // Byte offset within a word carries no meaning for word-wide accesses.
            wire w_unused_addr_lo = ^bus.addr_i[BYTE_BITS-1:0];
        end
    endgenerate

`ifdef ACC_BRIDGE_TIMEOUT_EN
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_LIM = DATA_WIDTH'(TIMEOUT_CYCLES);
    // The cycle that brings CYCLES up to the limit is the last BUSY cycle.
    assign w_timeout_hit = (w_cycles_inc == TIMEOUT_LIM);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; done from the accelerator beats a same-cycle timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_take_done = 1'b0;
        w_take_to   = 1'b0;
        case (r_state)
            S_IDLE:  if (w_start_req) w_state_nxt = S_START;
            S_START: w_state_nxt = S_BUSY;
            S_BUSY: begin
                if (acc_done_i) begin
                    w_state_nxt = S_DONE;
                    w_take_done = 1'b1;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_DONE;
                    w_take_to   = 1'b1;
                end
            end
            S_DONE:  if (w_start_req) w_state_nxt = S_START;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_clear_req) begin
            w_state_nxt = S_IDLE;
            w_take_done = 1'b0;
            w_take_to   = 1'b0;
        end
    end

    // Status flags: err is sticky, done/timeout restart with each accepted run.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_clear_req) begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_busy && (w_start_req || w_ab_wr)) r_err <= 1'b1;
            if (w_start_go) begin
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_take_done) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b0;
            end
            if (w_take_to) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

    // BUSY-cycle counter: zeroed on an accepted start, saturating.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i)                r_cycles <= '0;
        else if (w_start_go)        r_cycles <= '0;
        else if (r_state == S_BUSY) r_cycles <= w_cycles_inc;
    end

    // Operand banks: byte-enabled writes, dropped while the accelerator runs.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_bank_a <= '0;
            r_bank_b <= '0;
        end else if (w_ab_wr && !w_busy) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.be_i[b]) begin
                    if (w_region == REG_A) r_bank_a[w_word][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
                    else                   r_bank_b[w_word][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Result bank captures the accelerator output on a taken done.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i)          r_bank_r <= '0;
        else if (w_take_done) r_bank_r <= acc_out_i;
    end

    // Read-data mux over the four regions.
    always_comb begin
        w_rdata = '0;
        case (w_region)
            REG_A: w_rdata = r_bank_a[w_word];
            REG_B: w_rdata = r_bank_b[w_word];
            REG_R: w_rdata = r_bank_r[w_word];
            default: begin
                if (w_word == WORD_BITS'(1))
                    w_rdata = DATA_WIDTH'({r_timeout, r_err, r_done, w_busy});
                else if (w_word == WORD_BITS'(2))
                    w_rdata = r_cycles;
            end
        endcase
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i)                   r_rdata <= '0;
        else if (bus.en_i && !bus.we_i) r_rdata <= w_rdata;
    end
endmodule
